// File: rtl/dcache_miss_handler_if.sv
// Bus bundle between the D-cache controller, the miss handler and line memory.
// The slave modport is the miss handler's view.
interface dcache_miss_handler_if #(
    parameter int TAG_W = 5,
    parameter int IDX_W = 6
);
    logic                   miss_req;
    logic [TAG_W+IDX_W+1:0] miss_addr;
    logic                   victim_dirty;
    logic [TAG_W-1:0]       victim_tag;
    logic [63:0]            victim_line;
    logic                   mem_rdy;
    logic [63:0]            mem_rd_data;
    logic [TAG_W+IDX_W-1:0] mem_addr;
    logic [63:0]            mem_wdata;
    logic                   mem_we;
    logic                   mem_re;
    logic                   fill_we;
    logic [63:0]            fill_line;
    logic                   busy;
    logic                   stall;

    modport slave (
        input  miss_req, miss_addr, victim_dirty, victim_tag, victim_line,
        input  mem_rdy, mem_rd_data,
        output mem_addr, mem_wdata, mem_we, mem_re, fill_we, fill_line, busy, stall
    );

    modport master (
        output miss_req, miss_addr, victim_dirty, victim_tag, victim_line,
        output mem_rdy, mem_rd_data,
        input  mem_addr, mem_wdata, mem_we, mem_re, fill_we, fill_line, busy, stall
    );
endinterface

// File: rtl/dcache_miss_handler.sv
// D-cache miss handler: optional dirty-victim writeback, line fill, one-cycle install.
// Optional macro DCACHE_MISS_CNT_EN adds saturating miss/writeback counters.
module dcache_miss_handler #(
    parameter int TAG_W = 5,
    parameter int IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    dcache_miss_handler_if.slave bus_if
`ifdef DCACHE_MISS_CNT_EN
    ,
    output logic [15:0]          miss_cnt_o,
    output logic [15:0]          wb_cnt_o
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WB      = 2'd1,
        ST_FILL    = 2'd2,
        ST_INSTALL = 2'd3
    } state_e;

    state_e                 state_q;
    logic [TAG_W-1:0]       tag_q;
    logic [IDX_W-1:0]       idx_q;
    logic [TAG_W+IDX_W-1:0] mem_addr_q;
    logic [63:0]            mem_wdata_q;
    logic [63:0]            fill_line_q;
    logic                   mem_we_q;
    logic                   mem_re_q;
    logic                   fill_we_q;
    logic                   busy_q;

    logic [TAG_W-1:0]       req_tag;
    logic [IDX_W-1:0]       req_idx;

    assign req_tag = bus_if.miss_addr[TAG_W+IDX_W+1:IDX_W+2];
    assign req_idx = bus_if.miss_addr[IDX_W+1:2];

    // Miss FSM; the victim is captured straight into the memory-side output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tag_q       <= '0;
            idx_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 64'd0;
            fill_line_q <= 64'd0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            fill_we_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus_if.miss_req) begin
                        tag_q  <= req_tag;
                        idx_q  <= req_idx;
                        busy_q <= 1'b1;
                        if (bus_if.victim_dirty) begin
                            state_q     <= ST_WB;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {bus_if.victim_tag, req_idx};
                            mem_wdata_q <= bus_if.victim_line;
                        end else begin
                            state_q    <= ST_FILL;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= {req_tag, req_idx};
                        end
                    end
                end
                ST_WB: begin
                    if (bus_if.mem_rdy) begin
                        state_q    <= ST_FILL;
                        mem_we_q   <= 1'b0;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= {tag_q, idx_q};
                    end
                end
                ST_FILL: begin
                    if (bus_if.mem_rdy) begin
                        state_q     <= ST_INSTALL;
                        mem_re_q    <= 1'b0;
                        fill_line_q <= bus_if.mem_rd_data;
                        fill_we_q   <= 1'b1;
                    end
                end
                ST_INSTALL: begin
                    state_q   <= ST_IDLE;
                    fill_we_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_we_q  <= 1'b0;
                    mem_re_q  <= 1'b0;
                    fill_we_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.mem_addr  = mem_addr_q;
    assign bus_if.mem_wdata = mem_wdata_q;
    assign bus_if.mem_we    = mem_we_q;
    assign bus_if.mem_re    = mem_re_q;
    assign bus_if.fill_we   = fill_we_q;
    assign bus_if.fill_line = fill_line_q;
    assign bus_if.busy      = busy_q;
    assign bus_if.stall     = busy_q | bus_if.miss_req;

`ifdef DCACHE_MISS_CNT_EN
    logic [15:0] miss_cnt_q;
    logic [15:0] miss_cnt_d;
    logic [15:0] wb_cnt_q;
    logic [15:0] wb_cnt_d;
    logic        miss_accept;
    logic        wb_done;

    assign miss_accept = (state_q == ST_IDLE) && bus_if.miss_req;
    assign wb_done     = (state_q == ST_WB) && bus_if.mem_rdy;

    // Saturating event counters.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (miss_accept && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
        if (wb_done && (wb_cnt_q != 16'hFFFF)) begin
            wb_cnt_d = wb_cnt_q + 16'd1;
        end else begin
            wb_cnt_d = wb_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt_q <= 16'd0;
            wb_cnt_q   <= 16'd0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign miss_cnt_o = miss_cnt_q;
    assign wb_cnt_o   = wb_cnt_q;
`endif
endmodule

// File: doc/dcache_miss_handler.md
DCACHE_MISS_HANDLER -- requirements
Module: dcache_miss_handler

Interface
REQ-001 Parameter TAG_W, default 5, tag width; it SHALL match the D-cache tag_out width.
REQ-002 Parameter IDX_W, default 6, set-index width; the line address SHALL be miss_addr[IDX_W+1:2].
REQ-003 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 miss_req  in  1  cache controller reports a D-cache miss (re|we with hit=0).
REQ-006 miss_addr  in  TAG_W+IDX_W+2  word address of the missing access.
REQ-007 victim_dirty  in  1  dirty bit of the line being replaced.
REQ-008 victim_tag  in  TAG_W  tag of the line being replaced.
REQ-009 victim_line  in  64  data of the line being replaced.
REQ-010 mem_rdy  in  1  memory completion strobe, one cycle per transaction.
REQ-011 mem_rd_data  in  64  memory read line, valid only while mem_rdy=1.
REQ-012 mem_addr  out  TAG_W+IDX_W  line address to memory.
REQ-013 mem_wdata  out  64  writeback line.
REQ-014 mem_we / mem_re  out  1 each  memory write / read request, level-held until mem_rdy.
REQ-015 fill_we  out  1  one-cycle strobe installing fill_line into the D-cache, clean (wdirty=0).
REQ-016 fill_line  out  64  line to install.
REQ-017 busy  out  1  miss in progress.
REQ-018 stall  out  1  pipeline stall; it SHALL be combinational busy | miss_req.

Function
REQ-019 FSM states: IDLE, WB, FILL, INSTALL.
REQ-020 In IDLE with miss_req=1, the block SHALL latch miss_addr, victim_tag, victim_line and victim_dirty, then go to WB if victim_dirty=1, otherwise to FILL.
REQ-021 In WB: mem_we=1, mem_addr={victim_tag_q, idx_q}, mem_wdata=victim_line_q; on mem_rdy the FSM SHALL go to FILL.
REQ-022 In FILL: mem_re=1, mem_addr={tag_q, idx_q} from the latched miss_addr; on mem_rdy it SHALL capture mem_rd_data into fill_line and go to INSTALL.
REQ-023 In INSTALL: fill_we=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 mem_we and mem_re SHALL never be high together, and neither SHALL be high in IDLE or INSTALL.
REQ-025 busy SHALL be 1 in WB, FILL and INSTALL, and 0 in IDLE.
REQ-026 miss_req SHALL be ignored while busy; a request held high through INSTALL SHALL be accepted as a new miss on the first IDLE cycle.
REQ-027 mem_rdy in IDLE or INSTALL SHALL be ignored.
REQ-028 Request outputs and address/data SHALL stay stable from assertion until mem_rdy; there is no timeout.
REQ-029 Minimum latency, acceptance to fill_we: clean victim 2 cycles with zero-wait memory; dirty victim 3 cycles.
REQ-030 fill_line SHALL hold its value from capture until the next capture.

Reset
REQ-031 With rst=1, the FSM SHALL go to IDLE asynchronously, and busy, mem_we, mem_re and fill_we SHALL be 0 immediately; mem_addr, mem_wdata and fill_line SHALL be 0.
REQ-032 Reset during WB or FILL SHALL abort the transaction; no fill_we SHALL follow, and a mem_rdy arriving after reset SHALL be ignored.

Configuration
REQ-033 Macro DCACHE_MISS_CNT_EN: when defined, the block SHALL add outputs miss_cnt[15:0] and wb_cnt[15:0].
REQ-034 With DCACHE_MISS_CNT_EN: miss_cnt SHALL increment on each accepted miss, and wb_cnt SHALL increment on each WB completion.
REQ-035 With DCACHE_MISS_CNT_EN: both counters SHALL saturate at 16'hFFFF and reset to 0.
REQ-036 Without DCACHE_MISS_CNT_EN: the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-037 Clean miss: miss_addr=13'h0A5, victim_dirty=0, mem_rdy one cycle after mem_re, mem_rd_data=64'h1111_2222_3333_4444 -> mem_re with mem_addr=11'h029, no mem_we, fill_we one cycle with that line, busy then drops.
REQ-038 Dirty miss: victim_tag=5'h1F, miss_addr=13'h004, victim_line=64'hDEAD_BEEF_0000_0001 -> mem_we with mem_addr=11'h7C1 and that data until mem_rdy, then mem_re with mem_addr=11'h001, then fill_we.
REQ-039 Wait states: mem_rdy delayed 5 cycles in both WB and FILL -> mem_addr, mem_wdata, mem_we and mem_re are stable throughout, and stall=1 throughout.
REQ-040 Back-to-back: miss_req held high through the first miss -> second miss accepted the cycle after INSTALL with newly latched inputs; a spurious mem_rdy in IDLE causes no state change.
REQ-041 Reset mid-FILL: rst pulsed while mem_re=1 -> mem_re=0 and busy=0 in the same cycle, no fill_we, and a late mem_rdy is ignored.
REQ-042 DCACHE_MISS_CNT_EN defined: 3 misses, 1 of them dirty -> miss_cnt=3, wb_cnt=1; counters forced to 16'hFFFF stay at 16'hFFFF after another miss.
